// File: rtl/led_change_monitor.sv
`default_nettype none
// ============================================================================
// Module   : led_change_monitor
// Purpose  : Watches an LED bus, glitch-filters value changes, timestamps
//            each qualified change and queues {prev, new, ts} in a
//            show-ahead FIFO read with a valid/ready handshake.
// Ports    : CLK50MHZ     - system clock
//            RST_N        - asynchronous active-low reset
//            EN_i         - capture enable
//            CLR_i        - synchronous clear of counters and overflow flag
//            LED_i        - sampled LED bus
//            EVT_VALID_o  - FIFO head valid
//            EVT_READY_i  - consumer accepts head
//            EVT_PREV_o   - head: LED value before the change
//            EVT_LED_o    - head: LED value after the change
//            EVT_TS_o     - head: timestamp of first cycle new value was seen
//            EVT_CNT_o    - committed events (saturating)
//            DROP_CNT_o   - events lost to a full FIFO (saturating)
//            OVERFLOW_o   - sticky drop indicator
// Revision : 1.0 - initial release
// ============================================================================
module led_change_monitor #(
    parameter int               LED_W      = 8,
    parameter int               TS_W       = 32,
    parameter int               DEPTH      = 8,
    parameter int               FILTER_CYC = 2,
    parameter logic [LED_W-1:0] LED_RST    = '0
) (
    input  logic             CLK50MHZ,
    input  logic             RST_N,
    input  logic             EN_i,
    input  logic             CLR_i,
    input  logic [LED_W-1:0] LED_i,
    output logic             EVT_VALID_o,
    input  logic             EVT_READY_i,
    output logic [LED_W-1:0] EVT_PREV_o,
    output logic [LED_W-1:0] EVT_LED_o,
    output logic [TS_W-1:0]  EVT_TS_o,
    output logic [15:0]      EVT_CNT_o,
    output logic [15:0]      DROP_CNT_o,
    output logic             OVERFLOW_o
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(FILTER_CYC + 1);
    localparam int c_ENT_W = 2 * LED_W + TS_W;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(FILTER_CYC);
    localparam logic [c_AW:0]      c_FULL    = (c_AW + 1)'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_QUAL = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [TS_W-1:0]    r_ts;
    logic [LED_W-1:0]   r_ref;
    logic [LED_W-1:0]   r_cand, w_cand_nxt;
    logic [TS_W-1:0]    r_cand_ts, w_cand_ts_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic               w_commit;
    logic [LED_W-1:0]   w_commit_led;
    logic [TS_W-1:0]    w_commit_ts;

    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]      r_count;
    logic               w_empty, w_full, w_pop, w_push, w_drop;
    logic [c_ENT_W-1:0] w_head;

    // ------------------------------------------------------------------
    // Qualification FSM: next state and commit decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cand_nxt    = r_cand;
        w_cand_ts_nxt = r_cand_ts;
        w_cnt_nxt     = r_cnt;
        w_commit      = 1'b0;
        w_commit_led  = r_cand;
        w_commit_ts   = r_cand_ts;
        if (!EN_i) begin
            // Disabling abandons any candidate; ref is left untouched.
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (LED_i != r_ref) begin
                        w_cand_nxt    = LED_i;
                        w_cand_ts_nxt = r_ts;
                        w_cnt_nxt     = c_CNT_ONE;
                        if (FILTER_CYC == 1) begin
                            w_commit     = 1'b1;
                            w_commit_led = LED_i;
                            w_commit_ts  = r_ts;
                        end else begin
                            w_state_nxt = S_QUAL;
                        end
                    end
                end
                S_QUAL: begin
                    if (LED_i == r_cand) begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                        if (w_cnt_nxt == c_CNT_MAX) begin
                            w_commit    = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end else if (LED_i == r_ref) begin
                        // Bus bounced back: treat the excursion as a glitch.
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cand_nxt    = LED_i;
                        w_cand_ts_nxt = r_ts;
                        w_cnt_nxt     = c_CNT_ONE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_ts      <= '0;
            r_ref     <= LED_RST;
            r_cand    <= '0;
            r_cand_ts <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ts      <= r_ts + 1'b1;
            r_cand    <= w_cand_nxt;
            r_cand_ts <= w_cand_ts_nxt;
            r_cnt     <= w_cnt_nxt;
            // Reference advances on every commit, including dropped ones.
            if (w_commit) begin
                r_ref <= w_commit_led;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (show-ahead). A pop frees a slot for a same-cycle push.
    // ------------------------------------------------------------------
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_pop   = !w_empty && EVT_READY_i;
    assign w_push  = w_commit && (!w_full || w_pop);
    assign w_drop  = w_commit && w_full && !w_pop;

    always_ff @(posedge CLK50MHZ) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_ref, w_commit_led, w_commit_ts};
        end
    end

    always_ff @(posedge CLK50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Head data is forced to zero while empty so unwritten storage never leaks.
    assign w_head      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign EVT_VALID_o = !w_empty;
    assign EVT_PREV_o  = w_head[c_ENT_W-1 -: LED_W];
    assign EVT_LED_o   = w_head[TS_W +: LED_W];
    assign EVT_TS_o    = w_head[TS_W-1:0];

    // ------------------------------------------------------------------
    // Statistics. A same-cycle event takes precedence over a clear.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            EVT_CNT_o  <= '0;
            DROP_CNT_o <= '0;
            OVERFLOW_o <= 1'b0;
        end else begin
            if (w_commit) begin
                if (CLR_i) begin
                    EVT_CNT_o <= 16'd1;
                end else if (EVT_CNT_o != 16'hFFFF) begin
                    EVT_CNT_o <= EVT_CNT_o + 16'd1;
                end
            end else if (CLR_i) begin
                EVT_CNT_o <= '0;
            end

            if (w_drop) begin
                if (CLR_i) begin
                    DROP_CNT_o <= 16'd1;
                end else if (DROP_CNT_o != 16'hFFFF) begin
                    DROP_CNT_o <= DROP_CNT_o + 16'd1;
                end
            end else if (CLR_i) begin
                DROP_CNT_o <= '0;
            end

            if (w_drop) begin
                OVERFLOW_o <= 1'b1;
            end else if (CLR_i) begin
                OVERFLOW_o <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_change_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_change_monitor
// Purpose  : Directed self-checking bench for led_change_monitor. A main
//            instance (FILTER_CYC=3, DEPTH=8) covers filtering, overflow,
//            ordering, clear and reset; a narrow-timestamp instance
//            (TS_W=4, FILTER_CYC=1) covers timestamp wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_change_monitor;

    logic        clk = 1'b0;
    logic        rst_n, en, clr, ready;
    logic [7:0]  led;
    logic        valid;
    logic [7:0]  prev_o, led_o;
    logic [31:0] ts_o;
    logic [15:0] evt_cnt, drop_cnt;
    logic        ovf;

    logic        rst2_n, ready2;
    logic [7:0]  led2;
    logic        valid2;
    logic [7:0]  prev2_o, led2_o;
    logic [3:0]  ts2_o;
    logic [15:0] evt_cnt2, drop_cnt2;
    logic        ovf2;

    int tests = 0;
    int fails = 0;
    int tb_ts = 0;
    int tb_ts2 = 0;

    always #10 clk = ~clk;

    // Cycle counters since each reset release: the time base events are stamped with.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) tb_ts <= 0; else tb_ts <= tb_ts + 1;
    always @(posedge clk or negedge rst2_n)
        if (!rst2_n) tb_ts2 <= 0; else tb_ts2 <= tb_ts2 + 1;

    led_change_monitor #(
        .LED_W(8), .TS_W(32), .DEPTH(8), .FILTER_CYC(3), .LED_RST(8'h00)
    ) u_dut (
        .CLK50MHZ(clk), .RST_N(rst_n), .EN_i(en), .CLR_i(clr), .LED_i(led),
        .EVT_VALID_o(valid), .EVT_READY_i(ready), .EVT_PREV_o(prev_o),
        .EVT_LED_o(led_o), .EVT_TS_o(ts_o), .EVT_CNT_o(evt_cnt),
        .DROP_CNT_o(drop_cnt), .OVERFLOW_o(ovf)
    );

    led_change_monitor #(
        .LED_W(8), .TS_W(4), .DEPTH(4), .FILTER_CYC(1), .LED_RST(8'h00)
    ) u_dut_ts4 (
        .CLK50MHZ(clk), .RST_N(rst2_n), .EN_i(1'b1), .CLR_i(1'b0), .LED_i(led2),
        .EVT_VALID_o(valid2), .EVT_READY_i(ready2), .EVT_PREV_o(prev2_o),
        .EVT_LED_o(led2_o), .EVT_TS_o(ts2_o), .EVT_CNT_o(evt_cnt2),
        .DROP_CNT_o(drop_cnt2), .OVERFLOW_o(ovf2)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0]  exp_prev [10];
    logic [7:0]  exp_led  [10];
    logic [31:0] exp_ts   [10];
    logic [31:0] t;
    int          guard;

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        en = 1'b1; clr = 1'b0; ready = 1'b0; led = 8'h00;
        ready2 = 1'b0; led2 = 8'h00;
        step(2);

        // Reset state
        check("rst_valid",    64'(valid),    64'(0));
        check("rst_prev",     64'(prev_o),   64'(0));
        check("rst_led",      64'(led_o),    64'(0));
        check("rst_ts",       64'(ts_o),     64'(0));
        check("rst_evt_cnt",  64'(evt_cnt),  64'(0));
        check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
        check("rst_ovf",      64'(ovf),      64'(0));
        check("rst_valid2",   64'(valid2),   64'(0));
        rst_n = 1'b1; rst2_n = 1'b1;

        // Timestamp wrap on the 4-bit instance: change seen at ts=15
        guard = 0;
        while (tb_ts2 != 15 && guard < 100) begin step(); guard++; end
        if (guard >= 100) begin tests++; fails++; $error("FAIL wait_ts15: timed out"); end
        led2 = 8'h5A;
        step();
        check("w_valid",  64'(valid2),  64'(1));
        check("w_prev",   64'(prev2_o), 64'(8'h00));
        check("w_led",    64'(led2_o),  64'(8'h5A));
        check("w_ts15",   64'(ts2_o),   64'(4'hF));
        ready2 = 1'b1; step(); ready2 = 1'b0;
        check("w_popped", 64'(valid2),  64'(0));
        guard = 0;
        while (tb_ts2 != 20 && guard < 100) begin step(); guard++; end
        if (guard >= 100) begin tests++; fails++; $error("FAIL wait_ts20: timed out"); end
        led2 = 8'hA5;
        step();
        check("w_prev2",   64'(prev2_o), 64'(8'h5A));
        check("w_led2",    64'(led2_o),  64'(8'hA5));
        check("w_ts_wrap", 64'(ts2_o),   64'(4'h4));
        check("w_evt_cnt", 64'(evt_cnt2), 64'(2));

        // 1: 00 -> 05 held, event appears three cycles later
        led = 8'h05; t = 32'(tb_ts);
        step(2);
        check("t1_early_valid", 64'(valid),   64'(0));
        step();
        check("t1_valid",  64'(valid),   64'(1));
        check("t1_prev",   64'(prev_o),  64'(8'h00));
        check("t1_led",    64'(led_o),   64'(8'h05));
        check("t1_ts",     64'(ts_o),    64'(t));
        check("t1_evt",    64'(evt_cnt), 64'(1));
        ready = 1'b1; step(); ready = 1'b0;
        check("t1_popped", 64'(valid),   64'(0));

        // 2: glitch 05 -> FF for two cycles -> 05
        led = 8'hFF; step(2);
        led = 8'h05; step(4);
        check("t2_valid", 64'(valid),   64'(0));
        check("t2_evt",   64'(evt_cnt), 64'(1));

        // 3: ten qualified changes with no consumer
        for (int i = 0; i < 10; i++) begin
            exp_prev[i] = (i == 0) ? 8'h05 : 8'(8'h10 + i - 1);
            exp_led[i]  = 8'(8'h10 + i);
            led = exp_led[i]; exp_ts[i] = 32'(tb_ts);
            step(3);
        end
        check("t3_evt",  64'(evt_cnt),  64'(11));
        check("t3_drop", 64'(drop_cnt), 64'(2));
        check("t3_ovf",  64'(ovf),      64'(1));
        step(2);
        check("t3_hold_valid", 64'(valid),  64'(1));
        check("t3_hold_prev",  64'(prev_o), 64'(exp_prev[0]));
        check("t3_hold_led",   64'(led_o),  64'(exp_led[0]));
        check("t3_hold_ts",    64'(ts_o),   64'(exp_ts[0]));

        // 4: full FIFO, pop and commit land on the same edge
        led = 8'h20; t = 32'(tb_ts);
        step(2);
        ready = 1'b1; step(); ready = 1'b0;
        check("t4_drop", 64'(drop_cnt), 64'(2));
        check("t4_evt",  64'(evt_cnt),  64'(12));
        check("t4_ovf",  64'(ovf),      64'(1));
        ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("drain%0d_valid", k), 64'(valid), 64'(1));
            if (k < 7) begin
                check($sformatf("drain%0d_prev", k), 64'(prev_o), 64'(exp_prev[k+1]));
                check($sformatf("drain%0d_led", k),  64'(led_o),  64'(exp_led[k+1]));
                check($sformatf("drain%0d_ts", k),   64'(ts_o),   64'(exp_ts[k+1]));
            end else begin
                check("drain7_prev", 64'(prev_o), 64'(8'h19));
                check("drain7_led",  64'(led_o),  64'(8'h20));
                check("drain7_ts",   64'(ts_o),   64'(t));
            end
            step();
        end
        check("drain_empty", 64'(valid), 64'(0));
        step();
        check("ready_when_empty", 64'(valid), 64'(0));
        ready = 1'b0;

        // Clear, then a commit coinciding with a clear
        clr = 1'b1; step(); clr = 1'b0;
        check("clr_evt",  64'(evt_cnt),  64'(0));
        check("clr_drop", 64'(drop_cnt), 64'(0));
        check("clr_ovf",  64'(ovf),      64'(0));
        led = 8'h30; step(2);
        clr = 1'b1; step(); clr = 1'b0;
        check("clr_commit_evt", 64'(evt_cnt), 64'(1));
        check("clr_commit_led", 64'(led_o),   64'(8'h30));
        ready = 1'b1; step(); ready = 1'b0;

        // 5: reset while qualifying
        led = 8'h44; step();
        rst_n = 1'b0; #1;
        check("t5_valid", 64'(valid),   64'(0));
        check("t5_evt",   64'(evt_cnt), 64'(0));
        check("t5_ovf",   64'(ovf),     64'(0));
        led = 8'h00; step();
        rst_n = 1'b1; step(5);
        check("t5_no_evt_valid", 64'(valid),   64'(0));
        check("t5_no_evt_cnt",   64'(evt_cnt), 64'(0));

        // 6: changes while disabled, then one event on re-enable
        en = 1'b0;
        led = 8'h01; step(4);
        led = 8'h02; step(4);
        led = 8'h03; step(4);
        check("t6_dis_valid", 64'(valid),   64'(0));
        check("t6_dis_evt",   64'(evt_cnt), 64'(0));
        en = 1'b1; t = 32'(tb_ts);
        step(3);
        check("t6_valid", 64'(valid),   64'(1));
        check("t6_prev",  64'(prev_o),  64'(8'h00));
        check("t6_led",   64'(led_o),   64'(8'h03));
        check("t6_ts",    64'(ts_o),    64'(t));
        check("t6_evt",   64'(evt_cnt), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
